xadac_stage_vrf: RTL and testbench
==================================

// Module: xadac_stage_vrf
// PURPOSE
//  Vector register-file/issue stage placed directly upstream of the xadac VMACC execute stage.
//  - Accepts register-addressed vector ops from decode.
//  - Reads vs1/vs2/vs3 from a local register file and registers them toward execute.
//  - Writes execute's vd back in order and returns id/rd to decode.
//  - A per-register busy scoreboard blocks RAW and WAW hazards.
// PARAMETERS
//  NumRegs        32                      number of vector registers (power of 2)
//  VecWidth       xadac_pkg::VectorWidth  bits per vector register
//  IdWidth        xadac_pkg::IdWidth      op id width
//  ImmWidth       xadac_pkg::ImmWidth     immediate width (passed through unmodified)
//  MaxOutstanding 4                       in-flight ops awaiting writeback (power of 2, >=2)
// PORTS
//  clk          in   1         clock
//  rstn         in   1         async active-low reset
//  req_valid    in   1         decode op valid
//  req_ready    out  1         op accepted when valid&&ready
//  req_id       in   IdWidth   op id
//  req_vs1_addr in   log2(NR)  source 1 register
//  req_vs2_addr in   log2(NR)  source 2 register
//  req_vs3_addr in   log2(NR)  source 3 (accumulator) register
//  req_vd_addr  in   log2(NR)  destination register
//  req_we       in   1         op writes vd
//  req_imm      in   ImmWidth  immediate
//  dn_req_valid out  1         op to execute valid
//  dn_req_ready in   1         execute accepts
//  dn_req_id    out  IdWidth   id to execute
//  dn_req_imm   out  ImmWidth  immediate to execute
//  dn_req_vs1   out  VecWidth  source 1 data
//  dn_req_vs2   out  VecWidth  source 2 data
//  dn_req_vs3   out  VecWidth  source 3 data
//  dn_resp_valid in  1         execute result valid
//  dn_resp_ready out 1         equals resp_ready
//  dn_resp_id   in   IdWidth   result id
//  dn_resp_vd   in   VecWidth  result vector
//  dn_resp_rd   in   32        scalar result
//  resp_valid   out  1         equals dn_resp_valid
//  resp_ready   in   1         decode accepts response
//  resp_id      out  IdWidth   equals dn_resp_id
//  resp_rd      out  32        equals dn_resp_rd
// BEHAVIOUR
//  Reset values:
//  - Register file, busy bits, FIFO pointers and dn_req_* all clear to 0.
//  - req_ready=1 after reset.
//  Output register:
//  - Loads when (!dn_req_valid || dn_req_ready).
//  - Accept at cycle N gives dn_req_valid at N+1.
//  - dn_req_* hold stable while valid && !ready.
//  Accept condition (req_ready): slot loadable && FIFO not full && no hazard.
//  - hazard = busy[vs1]|busy[vs2]|busy[vs3]|(req_we&busy[vd]).
//  - req_ready is computed combinationally and never depends on req_valid.
//  On accept:
//  - Read the sources.
//  - Push {id,vd_addr,we} into the in-order pending FIFO.
//  - If we, set busy[vd].
//  Writeback on dn_resp handshake (dn_resp_valid&&resp_ready):
//  - Pop the FIFO.
//  - If we, write rf[vd_addr]<=dn_resp_vd and clear busy[vd_addr].
//  - Writeback and accept happen in one cycle when both handshakes fire.
//  - Set of busy wins over clear for the same register.
//  Response path is combinational, zero latency:
//  - resp_valid=dn_resp_valid.
//  - resp_id/rd pass through.
//  - dn_resp_ready=resp_ready.
//  Error cases (assertions only, no recovery):
//  - dn_resp_id != FIFO head id.
//  - Response while FIFO is empty.
//  Reset mid-operation: in-flight ops are dropped, scoreboard clears, and the next request is accepted normally.
// CONFIGURATION
//  XADAC_VRF_BYPASS_EN defined:
//  - A same-cycle writeback to a busy source (and not re-set) counts as not busy.
//  - dn_resp_vd is forwarded into the issued operand, so the op is accepted in the writeback cycle.
//  XADAC_VRF_BYPASS_EN undefined:
//  - The hazard uses registered busy only.
//  - A dependent op is accepted one cycle after the writeback.
// TESTING
//  1 Reset: after rstn rises -> req_ready=1, dn_req_valid=0, resp_valid=0.
//  2 Op id=5,vd=4,we=1; bench returns vd=0xA5, rd=7 -> resp_id=5, rd=7.
//    Then op vs1=4 -> dn_req_vs1=0xA5 one cycle after accept.
//  3 RAW: op A vd=7 we=1, then op B vs2=7 -> req_ready=0 until A's writeback.
//    B accepted at writeback+1 (no macro) or in the writeback cycle (macro).
//    dn_req_vs2 = A's vd in both cases.
//  4 Backpressure: dn_req_ready=0 for 3 cycles -> dn_req_* stable and the next op is held (req_ready=0).
//  5 Full: 4 ops accepted with no responses -> req_ready=0 for the 5th.
//    One response -> 5th accepted the next cycle.
//  6 we=0 op with vd=2 -> busy[2] stays 0, rf[2] unchanged after response.
//    Reset with 2 ops in flight -> busy cleared, FIFO empty.

Source files
------------

// File: rtl/xadac_stage_vrf.sv
// xadac_stage_vrf: vector register file / issue stage ahead of the xadac VMACC execute stage.
// Optional feature: define XADAC_VRF_BYPASS_EN to forward a same-cycle writeback into issue.
// Ports: clk, rstn (async active-low)
//        req_*      decode op in (register addresses, id, imm, we), req_ready back
//        dn_req_*   registered op with operand data toward execute
//        dn_resp_*  execute result (id, vd vector, rd scalar)
//        resp_*     zero-latency response pass-through to decode
package xadac_pkg;
    parameter int VectorWidth = 64;
    parameter int IdWidth = 4;
    parameter int ImmWidth = 8;
endpackage

module xadac_stage_vrf #(
    parameter int NumRegs = 32,
    parameter int VecWidth = xadac_pkg::VectorWidth,
    parameter int IdWidth = xadac_pkg::IdWidth,
    parameter int ImmWidth = xadac_pkg::ImmWidth,
    parameter int MaxOutstanding = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [IdWidth-1:0]         req_id,
    input  logic [$clog2(NumRegs)-1:0] req_vs1_addr,
    input  logic [$clog2(NumRegs)-1:0] req_vs2_addr,
    input  logic [$clog2(NumRegs)-1:0] req_vs3_addr,
    input  logic [$clog2(NumRegs)-1:0] req_vd_addr,
    input  logic                       req_we,
    input  logic [ImmWidth-1:0]        req_imm,
    output logic                       dn_req_valid,
    input  logic                       dn_req_ready,
    output logic [IdWidth-1:0]         dn_req_id,
    output logic [ImmWidth-1:0]        dn_req_imm,
    output logic [VecWidth-1:0]        dn_req_vs1,
    output logic [VecWidth-1:0]        dn_req_vs2,
    output logic [VecWidth-1:0]        dn_req_vs3,
    input  logic                       dn_resp_valid,
    output logic                       dn_resp_ready,
    input  logic [IdWidth-1:0]         dn_resp_id,
    input  logic [VecWidth-1:0]        dn_resp_vd,
    input  logic [31:0]                dn_resp_rd,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [IdWidth-1:0]         resp_id,
    output logic [31:0]                resp_rd
);
    localparam int AW = $clog2(NumRegs);
    localparam int PW = $clog2(MaxOutstanding);

    logic [VecWidth-1:0]       rf_q [NumRegs];
    logic [VecWidth-1:0]       rf_d [NumRegs];
    logic [NumRegs-1:0]        busy_q, busy_d, busy_v, wb_mask;
    logic [IdWidth-1:0]        fid_q [MaxOutstanding];
    logic [IdWidth-1:0]        fid_d [MaxOutstanding];
    logic [AW-1:0]             fvd_q [MaxOutstanding];
    logic [AW-1:0]             fvd_d [MaxOutstanding];
    logic [MaxOutstanding-1:0] fwe_q, fwe_d;
    logic [PW:0]               wr_q, wr_d, rd_q, rd_d;
    logic                      dn_valid_q, dn_valid_d;
    logic [IdWidth-1:0]        dn_id_q, dn_id_d;
    logic [ImmWidth-1:0]       dn_imm_q, dn_imm_d;
    logic [VecWidth-1:0]       dn_vs1_q, dn_vs1_d, dn_vs2_q, dn_vs2_d, dn_vs3_q, dn_vs3_d;
    logic [VecWidth-1:0]       op1, op2, op3;
    logic                      wb, wb_we, full, empty, slot, hazard, acc;
    logic [AW-1:0]             wb_addr;

    assign wb      = dn_resp_valid && resp_ready;
    assign wb_we   = wb && fwe_q[rd_q[PW-1:0]];
    assign wb_addr = fvd_q[rd_q[PW-1:0]];
    assign wb_mask = wb_we ? (NumRegs'(1) << wb_addr) : '0;
    assign full    = (wr_q ^ rd_q) == {1'b1, {PW{1'b0}}};
    assign empty   = wr_q == rd_q;
    assign slot    = !dn_valid_q || dn_req_ready;
`ifdef XADAC_VRF_BYPASS_EN
    // A register being written back this cycle is treated as free and its data forwarded.
    assign busy_v  = busy_q & ~wb_mask;
    assign op1     = (wb_we && wb_addr == req_vs1_addr) ? dn_resp_vd : rf_q[req_vs1_addr];
    assign op2     = (wb_we && wb_addr == req_vs2_addr) ? dn_resp_vd : rf_q[req_vs2_addr];
    assign op3     = (wb_we && wb_addr == req_vs3_addr) ? dn_resp_vd : rf_q[req_vs3_addr];
`else
    assign busy_v  = busy_q;
    assign op1     = rf_q[req_vs1_addr];
    assign op2     = rf_q[req_vs2_addr];
    assign op3     = rf_q[req_vs3_addr];
`endif
    assign hazard  = busy_v[req_vs1_addr] | busy_v[req_vs2_addr] | busy_v[req_vs3_addr]
                   | (req_we & busy_v[req_vd_addr]);
    assign req_ready = slot && !full && !hazard;
    assign acc       = req_valid && req_ready;

    assign dn_req_valid  = dn_valid_q;
    assign dn_req_id     = dn_id_q;
    assign dn_req_imm    = dn_imm_q;
    assign dn_req_vs1    = dn_vs1_q;
    assign dn_req_vs2    = dn_vs2_q;
    assign dn_req_vs3    = dn_vs3_q;
    assign resp_valid    = dn_resp_valid;
    assign resp_id       = dn_resp_id;
    assign resp_rd       = dn_resp_rd;
    assign dn_resp_ready = resp_ready;

    always_comb begin
        rf_d  = rf_q;
        fid_d = fid_q;
        fvd_d = fvd_q;
        fwe_d = fwe_q;
        if (wb_we) rf_d[wb_addr] = dn_resp_vd;
        if (acc) begin
            fid_d[wr_q[PW-1:0]] = req_id;
            fvd_d[wr_q[PW-1:0]] = req_vd_addr;
            fwe_d[wr_q[PW-1:0]] = req_we;
        end
        // Set is applied after clear so a re-claim of the same register wins.
        busy_d     = (busy_q & ~wb_mask) | ((acc && req_we) ? (NumRegs'(1) << req_vd_addr) : '0);
        wr_d       = wr_q + (PW+1)'(acc);
        rd_d       = rd_q + (PW+1)'(wb);
        dn_valid_d = slot ? acc : dn_valid_q;
        dn_id_d    = (slot && acc) ? req_id : dn_id_q;
        dn_imm_d   = (slot && acc) ? req_imm : dn_imm_q;
        dn_vs1_d   = (slot && acc) ? op1 : dn_vs1_q;
        dn_vs2_d   = (slot && acc) ? op2 : dn_vs2_q;
        dn_vs3_d   = (slot && acc) ? op3 : dn_vs3_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_q       <= '{default: '0};
            fid_q      <= '{default: '0};
            fvd_q      <= '{default: '0};
            fwe_q      <= '0;
            busy_q     <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            dn_valid_q <= 1'b0;
            dn_id_q    <= '0;
            dn_imm_q   <= '0;
            dn_vs1_q   <= '0;
            dn_vs2_q   <= '0;
            dn_vs3_q   <= '0;
        end else begin
            rf_q       <= rf_d;
            fid_q      <= fid_d;
            fvd_q      <= fvd_d;
            fwe_q      <= fwe_d;
            busy_q     <= busy_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            dn_valid_q <= dn_valid_d;
            dn_id_q    <= dn_id_d;
            dn_imm_q   <= dn_imm_d;
            dn_vs1_q   <= dn_vs1_d;
            dn_vs2_q   <= dn_vs2_d;
            dn_vs3_q   <= dn_vs3_d;
        end
    end

    a_resp_nonempty: assert property (@(posedge clk) disable iff (!rstn) wb |-> !empty);
    a_resp_in_order: assert property (@(posedge clk) disable iff (!rstn)
        (wb && !empty) |-> dn_resp_id == fid_q[rd_q[PW-1:0]]);
endmodule

// File: tb/tb_xadac_stage_vrf.sv
// tb_xadac_stage_vrf: randomized + directed scoreboard bench for xadac_stage_vrf.
module tb_xadac_stage_vrf;
    localparam int VW = xadac_pkg::VectorWidth;
    localparam int IW = xadac_pkg::IdWidth;
    localparam int MW = xadac_pkg::ImmWidth;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [IW-1:0] req_id = '0;
    logic [4:0]    req_vs1_addr = '0, req_vs2_addr = '0, req_vs3_addr = '0, req_vd_addr = '0;
    logic [MW-1:0] req_imm = '0;
    logic          dn_req_valid, dn_req_ready = 1'b0;
    logic [IW-1:0] dn_req_id;
    logic [MW-1:0] dn_req_imm;
    logic [VW-1:0] dn_req_vs1, dn_req_vs2, dn_req_vs3;
    logic          dn_resp_valid = 1'b0, dn_resp_ready;
    logic [IW-1:0] dn_resp_id = '0;
    logic [VW-1:0] dn_resp_vd = '0;
    logic [31:0]   dn_resp_rd = '0;
    logic          resp_valid, resp_ready = 1'b0;
    logic [IW-1:0] resp_id;
    logic [31:0]   resp_rd;

    xadac_stage_vrf dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_id(req_id),
        .req_vs1_addr(req_vs1_addr), .req_vs2_addr(req_vs2_addr), .req_vs3_addr(req_vs3_addr),
        .req_vd_addr(req_vd_addr), .req_we(req_we), .req_imm(req_imm),
        .dn_req_valid(dn_req_valid), .dn_req_ready(dn_req_ready), .dn_req_id(dn_req_id),
        .dn_req_imm(dn_req_imm), .dn_req_vs1(dn_req_vs1), .dn_req_vs2(dn_req_vs2),
        .dn_req_vs3(dn_req_vs3),
        .dn_resp_valid(dn_resp_valid), .dn_resp_ready(dn_resp_ready), .dn_resp_id(dn_resp_id),
        .dn_resp_vd(dn_resp_vd), .dn_resp_rd(dn_resp_rd),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_rd(resp_rd)
    );

    typedef struct { logic [IW-1:0] id; logic [MW-1:0] imm; logic [VW-1:0] v1, v2, v3; } req_t;
    typedef struct { logic [IW-1:0] id; logic [4:0] vd; logic we; } pend_t;
    typedef struct { logic [IW-1:0] id; logic [31:0] rd; } rsp_t;

    req_t          exp_q[$];
    pend_t         pend_q[$];
    logic [IW-1:0] exec_q[$];
    rsp_t          rsp_q[$];
    logic [VW-1:0] mrf [32];
    logic [31:0]   mbusy = '0;
    int            n_pass = 0, n_tot = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic wb_now();
        return dn_resp_valid && resp_ready && pend_q.size() != 0;
    endfunction

    function automatic logic model_ready();
        logic [31:0] b;
        b = mbusy;
`ifdef XADAC_VRF_BYPASS_EN
        if (wb_now() && pend_q[0].we) b[pend_q[0].vd] = 1'b0;
`endif
        return (exp_q.size() == 0 || dn_req_ready) && pend_q.size() < 4
            && !(b[req_vs1_addr] || b[req_vs2_addr] || b[req_vs3_addr] || (req_we && b[req_vd_addr]));
    endfunction

    function automatic logic [VW-1:0] mread(input logic [4:0] a);
`ifdef XADAC_VRF_BYPASS_EN
        if (wb_now() && pend_q[0].we && pend_q[0].vd == a) return dn_resp_vd;
`endif
        return mrf[a];
    endfunction

    task automatic model_clear();
        exp_q.delete(); pend_q.delete(); exec_q.delete(); rsp_q.delete();
        mbusy = '0;
        for (int i = 0; i < 32; i++) mrf[i] = '0;
    endtask

    // Advance the reference model by one clock using the inputs the bench is driving.
    task automatic model_step();
        logic  acc;
        req_t  r;
        pend_t p;
        acc = req_valid && model_ready();
        r = '{req_id, req_imm, mread(req_vs1_addr), mread(req_vs2_addr), mread(req_vs3_addr)};
        if (exp_q.size() != 0 && dn_req_ready) exec_q.push_back(exp_q.pop_front().id);
        if (wb_now()) begin
            p = pend_q.pop_front();
            void'(exec_q.pop_front());
            if (p.we) begin
                mrf[p.vd] = dn_resp_vd;
                mbusy[p.vd] = 1'b0;
            end
        end
        if (acc) begin
            exp_q.push_back(r);
            pend_q.push_back('{req_id, req_vd_addr, req_we});
            if (req_we) mbusy[req_vd_addr] = 1'b1;
        end
    endtask

    task automatic cyc(input logic v, input logic [IW-1:0] id, input logic [4:0] a1, a2, a3, d,
                       input logic we, input logic dnr, input logic rv, input logic rr,
                       input logic [VW-1:0] vd, input logic [31:0] rd);
        @(negedge clk);
        req_valid = v; req_id = id; req_vs1_addr = a1; req_vs2_addr = a2; req_vs3_addr = a3;
        req_vd_addr = d; req_we = we; req_imm = MW'($urandom);
        dn_req_ready = dnr; resp_ready = rr;
        dn_resp_valid = rv && exec_q.size() != 0;
        dn_resp_id = exec_q.size() != 0 ? exec_q[0] : '0;
        dn_resp_vd = vd; dn_resp_rd = rd;
        if (dn_resp_valid && resp_ready) rsp_q.push_back('{dn_resp_id, dn_resp_rd});
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input int n, input logic rv);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, rv, 1, {$urandom, $urandom}, $urandom);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; req_valid = 1'b0; dn_resp_valid = 1'b0;
        model_clear();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    always @(negedge clk) begin
        #2;
        if (rstn) begin
            chk("req_ready", req_ready, model_ready());
            chk("dn_req_valid", dn_req_valid, exp_q.size() != 0);
            if (dn_req_valid && exp_q.size() != 0) begin
                chk("dn_req_id", dn_req_id, exp_q[0].id);
                chk("dn_req_imm", dn_req_imm, exp_q[0].imm);
                chk("dn_req_vs1", dn_req_vs1, exp_q[0].v1);
                chk("dn_req_vs2", dn_req_vs2, exp_q[0].v2);
                chk("dn_req_vs3", dn_req_vs3, exp_q[0].v3);
            end
            chk("resp_valid", resp_valid, dn_resp_valid);
            chk("dn_resp_ready", dn_resp_ready, resp_ready);
            if (resp_valid && resp_ready) begin
                if (rsp_q.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    chk("resp_id", resp_id, e.id);
                    chk("resp_rd", resp_rd, e.rd);
                end
            end
        end
    end

    initial begin
        model_clear();
        do_reset();
        idle(2, 0);
        // op id=5 writes v4, then a reader of v4 sees the written-back value
        cyc(1, 5, 0, 0, 0, 4, 1, 1, 0, 1, '0, 0);
        idle(1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 64'hA5, 32'd7);
        cyc(1, 6, 4, 0, 0, 9, 0, 1, 0, 1, '0, 0);
        idle(3, 1);
        // RAW on v7: B is held until A writes back
        cyc(1, 1, 0, 0, 0, 7, 1, 1, 0, 1, '0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 2, 0, 7, 0, 3, 1, 1, 0, 1, '0, 0);
        cyc(1, 2, 0, 7, 0, 3, 1, 1, 1, 1, 64'h1234_5678_9ABC_DEF0, 32'h77);
        cyc(1, 2, 0, 7, 0, 3, 1, 1, 0, 1, '0, 0);
        idle(8, 1);
        // downstream backpressure holds the slot and blocks the next op
        cyc(1, 3, 1, 2, 3, 10, 1, 1, 0, 1, '0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 4, 5, 6, 8, 11, 1, 0, 0, 1, '0, 0);
        cyc(1, 4, 5, 6, 8, 11, 1, 1, 0, 1, '0, 0);
        idle(8, 1);
        // four outstanding fill the pending FIFO; a response frees a slot
        for (int i = 0; i < 4; i++) cyc(1, IW'(i + 8), 1, 1, 1, 1, 0, 1, 0, 1, '0, 0);
        for (int i = 0; i < 2; i++) cyc(1, 12, 1, 1, 1, 1, 0, 1, 0, 1, '0, 0);
        cyc(1, 12, 1, 1, 1, 1, 0, 1, 1, 1, {$urandom, $urandom}, $urandom);
        cyc(1, 12, 1, 1, 1, 1, 0, 1, 0, 1, '0, 0);
        idle(10, 1);
        // we=0 leaves v2 free and unwritten; then reset with two ops in flight
        cyc(1, 13, 0, 0, 0, 2, 0, 1, 0, 1, '0, 0);
        idle(4, 1);
        cyc(1, 14, 2, 2, 2, 2, 1, 1, 0, 1, '0, 0);
        cyc(1, 15, 0, 0, 0, 5, 1, 1, 0, 1, '0, 0);
        do_reset();
        cyc(1, 1, 2, 5, 0, 5, 1, 1, 0, 1, '0, 0);
        idle(4, 1);
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) do_reset();
            cyc($urandom_range(0, 3) != 0, IW'($urandom), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 3) != 0,
                {$urandom, $urandom}, $urandom);
        end
        idle(12, 1);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
